// File: rtl/audio_pcie_pkg.sv
// Shared types and constants for the audio-to-PCIe burst reader.
package audio_pcie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam int unsigned WORD_BYTES = 16;
  localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

  // One extra bit so offset+len can reach RING_WORDS before wrapping.
  function automatic int ring_off_width(input int ring_words);
    return $clog2(ring_words) + 1;
  endfunction

endpackage

// File: rtl/audio_pcie_skid2.sv
// Two-entry valid/ready skid buffer; the head entry is held while the sink stalls.
module audio_pcie_skid2
  import audio_pcie_pkg::*;
#(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] head_r;
  logic [DATA_WIDTH-1:0] tail_r;
  logic [1:0]            cnt_r;
  logic                  pop_s;

  assign pop_s     = out_valid & out_ready;
  assign out_valid = (cnt_r != 2'd0);
  assign out_data  = head_r;
  assign count     = cnt_r;

  // Entry storage: new data lands in head when empty, otherwise behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= {DATA_WIDTH{1'b0}};
      tail_r <= {DATA_WIDTH{1'b0}};
      cnt_r  <= 2'd0;
    end else begin
      case ({in_valid, pop_s})
        2'b10: begin
          if (cnt_r == 2'd0) head_r <= in_data;
          else               tail_r <= in_data;
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          head_r <= tail_r;
          cnt_r  <= cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd1) begin
            head_r <= in_data;
          end else begin
            head_r <= tail_r;
            tail_r <= in_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/audio_pcie_burst_reader.sv
// Drains the audio FIFO read side into fixed-size PCIe DMA bursts on a host ring buffer.
// Optional idle-timeout partial flush is built when AUDIO_PCIE_TIMEOUT_FLUSH_EN is defined.
module audio_pcie_burst_reader
  import audio_pcie_pkg::*;
#(
  parameter int DATA_WIDTH  = 128,
  parameter int LEVEL_WIDTH = 11,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int RING_WORDS  = 4096,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   dma_req,
  output logic [ADDR_WIDTH-1:0]  dma_addr,
  output logic [LEVEL_WIDTH-1:0] dma_len,
  input  logic                   dma_ack,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [31:0]            burst_cnt,
  output logic                   busy
);

  localparam int OFF_W = ring_off_width(RING_WORDS);
  localparam logic [LEVEL_WIDTH-1:0] BURST_LEN_L  = LEVEL_WIDTH'(BURST_LEN);
  localparam logic [OFF_W-1:0]       RING_WORDS_L = OFF_W'(RING_WORDS);
  localparam logic [LEVEL_WIDTH-1:0] ONE_L        = LEVEL_WIDTH'(1'b1);

  state_e                 state_r, state_s;
  logic                   en_d_r, inflight_r;
  logic [ADDR_WIDTH-1:0]  base_r, dma_addr_r, base_next_s;
  logic [OFF_W-1:0]       off_r, off_next_s, off_sum_s;
  logic [LEVEL_WIDTH-1:0] dma_len_r, rd_left_r, tx_left_r, start_len_s;
  logic [31:0]            burst_cnt_r;
  logic                   rise_s, start_s, rd_en_s, xfer_s;
  logic [1:0]             skid_cnt_s;
  logic [2:0]             occ_s;

  assign rise_s      = enable & ~en_d_r;
  assign base_next_s = rise_s ? base_addr : base_r;
  assign off_next_s  = rise_s ? {OFF_W{1'b0}} : off_r;
  assign off_sum_s   = off_r + OFF_W'(dma_len_r);
  assign xfer_s      = m_valid & m_ready;
  // Occupancy counts the word leaving this cycle as gone, so reads keep pace at one per cycle.
  assign occ_s       = {1'b0, skid_cnt_s} + {2'b00, inflight_r} - {2'b00, xfer_s};
  assign rd_en_s     = (state_r == ST_XFER) && (rd_left_r != {LEVEL_WIDTH{1'b0}}) &&
                       !fifo_rd_empty && (occ_s < 3'd2);

`ifdef AUDIO_PCIE_TIMEOUT_FLUSH_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0]        idle_cnt_r;
  logic                   partial_s, flush_s;
  logic [OFF_W-1:0]       room_s;
  logic [LEVEL_WIDTH-1:0] req_len_s;

  assign partial_s = enable && (fifo_rd_water_level != {LEVEL_WIDTH{1'b0}}) &&
                     (fifo_rd_water_level < BURST_LEN_L);
  assign flush_s   = partial_s && (idle_cnt_r == TO_W'(TIMEOUT_CYC - 1));
  assign room_s    = RING_WORDS_L - off_next_s;

  // Idle timer: counts idle cycles spent holding a partial burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             idle_cnt_r <= {TO_W{1'b0}};
    else if ((state_r == ST_IDLE) && partial_s && !flush_s) idle_cnt_r <= idle_cnt_r + TO_W'(1'b1);
    else                                                    idle_cnt_r <= {TO_W{1'b0}};
  end

  // Start decision: whole bursts first, else a timed-out partial flush, clipped at the ring end.
  always_comb begin
    start_s   = 1'b0;
    req_len_s = BURST_LEN_L;
    if ((state_r == ST_IDLE) && enable && (fifo_rd_water_level >= BURST_LEN_L)) begin
      start_s   = 1'b1;
      req_len_s = BURST_LEN_L;
    end else if ((state_r == ST_IDLE) && flush_s) begin
      start_s   = 1'b1;
      req_len_s = fifo_rd_water_level;
    end else begin
      start_s   = 1'b0;
      req_len_s = BURST_LEN_L;
    end
    start_len_s = (32'(req_len_s) > 32'(room_s)) ? LEVEL_WIDTH'(room_s) : req_len_s;
  end
`else
  // Start decision: only whole bursts are ever requested.
  always_comb begin
    start_s     = 1'b0;
    start_len_s = BURST_LEN_L;
    if ((state_r == ST_IDLE) && enable && (fifo_rd_water_level >= BURST_LEN_L)) start_s = 1'b1;
    else                                                                        start_s = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (start_s) state_s = ST_REQ;  else state_s = ST_IDLE;
      ST_REQ:  if (dma_ack) state_s = ST_XFER; else state_s = ST_REQ;
      ST_XFER: if (xfer_s && (tx_left_r == ONE_L)) state_s = ST_DONE; else state_s = ST_XFER;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Ring pointer, burst request registers and per-burst read/send counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d_r      <= 1'b0;
      inflight_r  <= 1'b0;
      base_r      <= {ADDR_WIDTH{1'b0}};
      off_r       <= {OFF_W{1'b0}};
      dma_addr_r  <= {ADDR_WIDTH{1'b0}};
      dma_len_r   <= {LEVEL_WIDTH{1'b0}};
      rd_left_r   <= {LEVEL_WIDTH{1'b0}};
      tx_left_r   <= {LEVEL_WIDTH{1'b0}};
      burst_cnt_r <= 32'd0;
    end else begin
      en_d_r     <= enable;
      inflight_r <= rd_en_s;
      case (state_r)
        ST_IDLE: begin
          if (rise_s) begin
            base_r <= base_addr;
            off_r  <= {OFF_W{1'b0}};
          end
          if (start_s) begin
            dma_addr_r <= base_next_s + (ADDR_WIDTH'(off_next_s) << WORD_SHIFT);
            dma_len_r  <= start_len_s;
          end
        end
        ST_REQ: begin
          if (dma_ack) begin
            rd_left_r <= dma_len_r;
            tx_left_r <= dma_len_r;
          end
        end
        ST_XFER: begin
          if (rd_en_s) rd_left_r <= rd_left_r - ONE_L;
          if (xfer_s)  tx_left_r <= tx_left_r - ONE_L;
        end
        ST_DONE: begin
          off_r       <= (off_sum_s >= RING_WORDS_L) ? {OFF_W{1'b0}} : off_sum_s;
          burst_cnt_r <= burst_cnt_r + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  audio_pcie_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (inflight_r),
    .in_data   (fifo_rd_data),
    .out_valid (m_valid),
    .out_data  (m_data),
    .out_ready (m_ready),
    .count     (skid_cnt_s)
  );

  assign fifo_rd_en = rd_en_s;
  assign dma_req    = (state_r == ST_REQ);
  assign dma_addr   = dma_addr_r;
  assign dma_len    = dma_len_r;
  assign m_last     = m_valid && (tx_left_r == ONE_L);
  assign burst_cnt  = burst_cnt_r;
  assign busy       = (state_r != ST_IDLE);

endmodule
